// File: rtl/instr_fetch.sv
// Instruction fetch stage: requests one word from instruction memory, holds it
// for decode until accepted, and stops permanently (until reset) on HALT_INSTR.
module instr_fetch #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter logic [15:0] HALT_INSTR = 16'hFFFF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] pc_next,
  output logic [15:0] pc,
  output logic [15:0] imem_addr,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [15:0] imem_data,
  output logic [15:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic        halted,
  output logic [15:0] fetch_count
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] pc_nxt;
  logic [15:0] instr_nxt;
  logic [15:0] count_nxt;

  // Handshake outputs come straight from the state register, so neither
  // imem_ack nor instr_ready can reach them combinationally.
  assign imem_req    = (state == FETCH);
  assign instr_valid = (state == HOLD);
  assign halted      = (state == HALT);
  assign imem_addr   = pc;

  always_comb begin
    // NOTE: every variable gets a hold-value default before the case, so no
    // branch can leave one unassigned and infer a latch.
    state_nxt = state;
    pc_nxt    = pc;
    instr_nxt = instr;
    count_nxt = fetch_count;

    case (state)
      FETCH: begin
        if (imem_ack) begin
          instr_nxt = imem_data;
          state_nxt = HOLD;
        end
      end

      HOLD: begin
        if (instr_ready) begin
          count_nxt = fetch_count + 16'd1;
          if (instr == HALT_INSTR) begin
            state_nxt = HALT;
          end else begin
            pc_nxt    = pc_next;
            state_nxt = FETCH;
          end
        end
      end

      HALT: begin
        state_nxt = HALT;
      end

      default: begin
        state_nxt = FETCH;
      end
    endcase
  end

  // NOTE: non-blocking assignments make every register update from the same
  // pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      instr       <= 16'h0000;
      fetch_count <= 16'h0000;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      instr       <= instr_nxt;
      fetch_count <= count_nxt;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed vector table, hand-written
// corner sequences, and randomized traffic against a transaction-level model.
module tb_instr_fetch;

  localparam logic [15:0] RST_PC = 16'h0000;
  localparam logic [15:0] HALT_W = 16'hFFFF;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] pc_next = '0;
  logic [15:0] pc;
  logic [15:0] imem_addr;
  logic        imem_req;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_data = '0;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        halted;
  logic [15:0] fetch_count;

  int n_cmp  = 0;
  int n_fail = 0;

  instr_fetch #(.RESET_PC(RST_PC), .HALT_INSTR(HALT_W)) dut (
    .clock       (clock),
    .reset       (reset),
    .pc_next     (pc_next),
    .pc          (pc),
    .imem_addr   (imem_addr),
    .imem_req    (imem_req),
    .imem_ack    (imem_ack),
    .imem_data   (imem_data),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .halted      (halted),
    .fetch_count (fetch_count)
  );

  always #5 clock = ~clock;

  // Transaction-level model: a one-deep buffer of words handed to decode.
  logic [15:0] m_buf[$];
  bit          m_halted;
  logic [15:0] m_pc, m_instr, m_cnt;

  typedef struct {
    logic        rst;
    logic        ack;
    logic [15:0] data;
    logic        rdy;
    logic [15:0] pcn;
    logic [15:0] e_pc;
    logic [15:0] e_instr;
    logic        e_valid;
    logic        e_req;
    logic        e_halt;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic [15:0] w;
    if (reset) begin
      m_buf.delete();
      m_halted = 1'b0;
      m_pc     = RST_PC;
      m_instr  = 16'h0000;
      m_cnt    = 16'h0000;
    end else if (!m_halted) begin
      if (m_buf.size() == 0) begin
        if (imem_ack) begin
          m_buf.push_back(imem_data);
          m_instr = imem_data;
        end
      end else if (instr_ready) begin
        w = m_buf.pop_front();
        m_cnt = m_cnt + 16'd1;
        if (w == HALT_W) m_halted = 1'b1;
        else m_pc = pc_next;
      end
    end
  endtask

  task automatic step(input logic r, input logic a, input logic [15:0] d,
                      input logic y, input logic [15:0] pn);
    reset       = r;
    imem_ack    = a;
    imem_data   = d;
    instr_ready = y;
    pc_next     = pn;
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".pc"},          pc,          m_pc);
    check({tag, ".imem_addr"},   imem_addr,   m_pc);
    check({tag, ".instr"},       instr,       m_instr);
    check({tag, ".instr_valid"}, 16'(instr_valid), 16'(m_buf.size() == 1));
    check({tag, ".imem_req"},    16'(imem_req),    16'(!m_halted && m_buf.size() == 0));
    check({tag, ".halted"},      16'(halted),      16'(m_halted));
    check({tag, ".fetch_count"}, fetch_count, m_cnt);
  endtask

  initial begin
    // rst ack data    rdy pcn      | pc       instr    v  req h  cnt
    vecs.push_back(vec_t'{1, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 0, 1, 0, 16'd0});
    vecs.push_back(vec_t'{0, 1, 16'h0011, 1, 16'h0001, 16'h0000, 16'h0011, 1, 0, 0, 16'd0});
    vecs.push_back(vec_t'{0, 1, 16'h0022, 1, 16'h0001, 16'h0001, 16'h0011, 0, 1, 0, 16'd1});
    vecs.push_back(vec_t'{0, 1, 16'h0022, 1, 16'h0002, 16'h0001, 16'h0022, 1, 0, 0, 16'd1});
    vecs.push_back(vec_t'{0, 1, 16'h0033, 1, 16'h0002, 16'h0002, 16'h0022, 0, 1, 0, 16'd2});
    vecs.push_back(vec_t'{0, 1, 16'h0033, 1, 16'h0003, 16'h0002, 16'h0033, 1, 0, 0, 16'd2});
    vecs.push_back(vec_t'{0, 1, 16'h0044, 1, 16'h0003, 16'h0003, 16'h0033, 0, 1, 0, 16'd3});
    for (int i = 0; i < 4; i++)
      vecs.push_back(vec_t'{0, 0, 16'h1234, 1, 16'h0009, 16'h0003, 16'h0033, 0, 1, 0, 16'd3});
    vecs.push_back(vec_t'{0, 1, 16'h1234, 0, 16'h0009, 16'h0003, 16'h1234, 1, 0, 0, 16'd3});
    vecs.push_back(vec_t'{0, 0, 16'h0000, 1, 16'h0004, 16'h0004, 16'h1234, 0, 1, 0, 16'd4});
    vecs.push_back(vec_t'{0, 1, 16'hABCD, 0, 16'h0000, 16'h0004, 16'hABCD, 1, 0, 0, 16'd4});
    vecs.push_back(vec_t'{0, 1, 16'h5555, 0, 16'h0099, 16'h0004, 16'hABCD, 1, 0, 0, 16'd4});
    vecs.push_back(vec_t'{0, 0, 16'h5555, 0, 16'h0099, 16'h0004, 16'hABCD, 1, 0, 0, 16'd4});
    vecs.push_back(vec_t'{0, 1, 16'h5555, 0, 16'h0099, 16'h0004, 16'hABCD, 1, 0, 0, 16'd4});
    vecs.push_back(vec_t'{0, 0, 16'h0000, 1, 16'h0010, 16'h0010, 16'hABCD, 0, 1, 0, 16'd5});
    vecs.push_back(vec_t'{0, 1, 16'h0007, 0, 16'h0000, 16'h0010, 16'h0007, 1, 0, 0, 16'd5});
    vecs.push_back(vec_t'{0, 0, 16'h0000, 1, 16'h0002, 16'h0002, 16'h0007, 0, 1, 0, 16'd6});
    vecs.push_back(vec_t'{0, 1, 16'hFFFF, 0, 16'h0000, 16'h0002, 16'hFFFF, 1, 0, 0, 16'd6});
    vecs.push_back(vec_t'{0, 0, 16'h0000, 1, 16'h0050, 16'h0002, 16'hFFFF, 0, 0, 1, 16'd7});
    vecs.push_back(vec_t'{0, 1, 16'h1111, 1, 16'h0060, 16'h0002, 16'hFFFF, 0, 0, 1, 16'd7});
    vecs.push_back(vec_t'{0, 1, 16'h2222, 1, 16'h0070, 16'h0002, 16'hFFFF, 0, 0, 1, 16'd7});
    vecs.push_back(vec_t'{1, 1, 16'h3333, 1, 16'h0080, 16'h0000, 16'h0000, 0, 1, 0, 16'd0});
    vecs.push_back(vec_t'{0, 1, 16'h4321, 0, 16'h0000, 16'h0000, 16'h4321, 1, 0, 0, 16'd0});
    vecs.push_back(vec_t'{1, 1, 16'h5678, 1, 16'h0077, 16'h0000, 16'h0000, 0, 1, 0, 16'd0});
    vecs.push_back(vec_t'{0, 1, 16'hFFFE, 1, 16'h0001, 16'h0000, 16'hFFFE, 1, 0, 0, 16'd0});

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].ack, vecs[i].data, vecs[i].rdy, vecs[i].pcn);
      check($sformatf("vec%0d.pc", i),          pc,                  vecs[i].e_pc);
      check($sformatf("vec%0d.imem_addr", i),   imem_addr,           vecs[i].e_pc);
      check($sformatf("vec%0d.instr", i),       instr,               vecs[i].e_instr);
      check($sformatf("vec%0d.instr_valid", i), 16'(instr_valid),    16'(vecs[i].e_valid));
      check($sformatf("vec%0d.imem_req", i),    16'(imem_req),       16'(vecs[i].e_req));
      check($sformatf("vec%0d.halted", i),      16'(halted),         16'(vecs[i].e_halt));
      check($sformatf("vec%0d.fetch_count", i), fetch_count,         vecs[i].e_cnt);
    end

    // Handshake outputs must not react to inputs between clock edges.
    step(1, 0, 16'h0000, 0, 16'h0000);
    reset = 1'b0; imem_ack = 1'b1; instr_ready = 1'b1; #2;
    check("comb_fetch.imem_req", 16'(imem_req), 16'd1);
    check("comb_fetch.instr_valid", 16'(instr_valid), 16'd0);
    step(0, 1, 16'h0A0A, 0, 16'h0000);
    instr_ready = 1'b1; imem_ack = 1'b0; #2;
    check("comb_hold.imem_req", 16'(imem_req), 16'd0);
    check("comb_hold.instr_valid", 16'(instr_valid), 16'd1);
    instr_ready = 1'b0; #2;
    check("comb_hold2.instr_valid", 16'(instr_valid), 16'd1);

    // pc follows pc_next verbatim across the 16-bit wrap.
    step(0, 0, 16'h0000, 1, 16'hFFFE);
    check("wrap.pc_fffe", pc, 16'hFFFE);
    step(0, 1, 16'h0B0B, 0, 16'h0000);
    step(0, 0, 16'h0000, 1, 16'h0000);
    check("wrap.pc_0000", pc, 16'h0000);
    check("wrap.imem_addr", imem_addr, 16'h0000);
    check("wrap.fetch_count", fetch_count, 16'd2);

    // Halt persists for many cycles while memory keeps acking.
    step(0, 1, HALT_W, 0, 16'h0000);
    step(0, 0, 16'h0000, 1, 16'h0123);
    for (int i = 0; i < 8; i++) step(0, 1, 16'h0C0C, 1, 16'h0456);
    check("halt_long.halted", 16'(halted), 16'd1);
    check("halt_long.imem_req", 16'(imem_req), 16'd0);
    check("halt_long.fetch_count", fetch_count, 16'd3);
    check("halt_long.pc", pc, 16'h0000);

    // Randomized traffic against the model.
    step(1, 0, 16'h0000, 0, 16'h0000);
    for (int i = 0; i < 3000; i++) begin
      logic        r, a, y;
      logic [15:0] d;
      r = ($urandom_range(0, 99) == 0);
      a = ($urandom_range(0, 1) == 1);
      y = ($urandom_range(0, 2) != 0);
      d = ($urandom_range(0, 29) == 0) ? HALT_W : 16'($urandom);
      step(r, a, d, y, 16'($urandom));
      check_model($sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
